// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// a constant-evaluable clog2 and the clear/run state encoding.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard_mp_busy_tbl.sv
// Busy-bit vector for the register file: flush beats reserve, reserve beats
// write-back on the same register; x0 never becomes busy.
import rf_pkg::*;

module rf_busy_tbl #(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int AW     = clog2(NREGS_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (en) begin
      if (flush) begin
        busy_nxt = '0;
      end else begin
        // Reserve is applied last so a newer producer outranks the write-back.
        if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy[rd_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/rf_scoreboard_mp.sv
// Multi-read-port register file with busy scoreboard and post-reset clear
// sequence. Define RF_BYPASS_EN for same-cycle write-through to the read ports.
import rf_pkg::*;

module rf_scoreboard_mp #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic                   flush
);

  rf_state_t        state;
  logic [AW-1:0]    clr_ptr;
  logic             run;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [XLEN-1:0]  ram_data;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NUM_RD-1:0] busy_raw;

  assign run = (state == RF_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        RF_INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(NREGS - 1)) begin
            state     <= RF_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= RF_RUN;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared by the clear sequence and write-back keeps the
  // storage mappable to a RAM with no reset.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = wr_addr;
    ram_data = wr_data;
    if (!run) begin
      ram_we   = 1'b1;
      ram_addr = clr_ptr;
      ram_data = '0;
    end else if (wr_en && (wr_addr != '0)) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) regs[ram_addr] <= ram_data;
  end

  rf_busy_tbl #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (run),
    .flush    (flush),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (busy_raw)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      a = rd_addr[p*AW +: AW];
      d = regs[a];
      b = busy_raw[p];
`ifdef RF_BYPASS_EN
      if (wr_en && (wr_addr == a) && (a != '0)) begin
        d = wr_data;
        b = 1'b0;
      end
`endif
      if (!init_done || (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[p*XLEN +: XLEN] = d;
      rd_busy[p]              = b;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard_mp.sv
// Directed bench for rf_scoreboard_mp: reset/clear timing, read/write, bypass,
// scoreboard priority, flush and mid-run reset.
module tb_rf_scoreboard_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   init_done;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   flush;

  int n_vec = 0;
  int n_err = 0;
  int cnt;
  logic [XLEN-1:0] exp_byp;

  rf_scoreboard_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr[0 +: AW]  = a0;
    rd_addr[AW +: AW] = a1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    cnt = 0;
    while (!init_done && cnt < 100) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, 32);
  endtask

  initial begin
    // 1: reset and clear sequence
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("init_done_in_reset", {31'd0, init_done}, 32'd0);
    rst_n = 1'b1;
    set_rd(5'd5, 5'd31);
    #1;
    chk("rd_data0_during_init", rd_data[31:0], 32'd0);
    wait_init("init_cycles");
    chk("init_done_after", {31'd0, init_done}, 32'd1);
    for (int r = 0; r < NREGS; r++) begin
      set_rd(AW'(r), AW'(NREGS - 1 - r));
      #1;
      chk("clear_data0", rd_data[31:0], 32'd0);
      chk("clear_data1", rd_data[63:32], 32'd0);
      chk("clear_busy", {30'd0, rd_busy}, 32'd0);
    end

    // 2: write then read, x0 stays zero
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    set_rd(5'd5, 5'd0);
    tick();
    idle();
    #1;
    chk("x5_readback", rd_data[31:0], 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    idle();
    set_rd(5'd0, 5'd5);
    #1;
    chk("x0_zero", rd_data[31:0], 32'd0);
    chk("x5_port1", rd_data[63:32], 32'hDEAD_BEEF);

    // 3: same-cycle write and read
`ifdef RF_BYPASS_EN
    exp_byp = 32'hA5A5_A5A5;
`else
    exp_byp = 32'd0;
`endif
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    set_rd(5'd5, 5'd7);
    #1;
    chk("x7_same_cycle", rd_data[63:32], exp_byp);
    chk("x7_same_busy", {31'd0, rd_busy[1]}, 32'd0);
    tick();
    idle();
    #1;
    chk("x7_next_cycle", rd_data[63:32], 32'hA5A5_A5A5);

    // 4: scoreboard reserve / write-back / collision
    rsv_en = 1'b1; rsv_addr = 5'd3;
    set_rd(5'd3, 5'd7);
    #1;
    chk("x3_busy_before", {31'd0, rd_busy[0]}, 32'd0);
    tick();
    idle();
    #1;
    chk("x3_busy_set", {31'd0, rd_busy[0]}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1;
`ifdef RF_BYPASS_EN
    chk("x3_wb_same_busy", {31'd0, rd_busy[0]}, 32'd0);
    chk("x3_wb_same_data", rd_data[31:0], 32'h33);
`else
    chk("x3_wb_same_busy", {31'd0, rd_busy[0]}, 32'd1);
    chk("x3_wb_same_data", rd_data[31:0], 32'd0);
`endif
    tick();
    idle();
    #1;
    chk("x3_busy_clr", {31'd0, rd_busy[0]}, 32'd0);
    chk("x3_data", rd_data[31:0], 32'h33);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
    tick();
    idle();
    #1;
    chk("x3_rsv_wins", {31'd0, rd_busy[0]}, 32'd1);
    chk("x3_data_upd", rd_data[31:0], 32'h44);

    // 5: flush
    rsv_en = 1'b1; rsv_addr = 5'd1; tick();
    rsv_addr = 5'd2; tick();
    rsv_addr = 5'd4; tick();
    idle();
    set_rd(5'd1, 5'd2);
    #1;
    chk("busy_x1_x2", {30'd0, rd_busy}, 32'd3);
    set_rd(5'd4, 5'd0);
    #1;
    chk("busy_x4", {30'd0, rd_busy}, 32'd1);
    flush = 1'b1;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    tick();
    idle();
    set_rd(5'd1, 5'd2);
    #1;
    chk("flush_x1_x2", {30'd0, rd_busy}, 32'd0);
    chk("flush_x2_data", rd_data[63:32], 32'h55);
    set_rd(5'd4, 5'd6);
    #1;
    chk("flush_x4_x6", {30'd0, rd_busy}, 32'd0);
    set_rd(5'd3, 5'd0);
    #1;
    chk("flush_x3", {30'd0, rd_busy}, 32'd0);

    // 6: mid-run reset with ops held during the clear
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    idle();
    set_rd(5'd9, 5'd5);
    #1;
    chk("x9_before_rst", rd_data[31:0], 32'h99);
    rst_n = 1'b0;
    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rd_data", rd_data[31:0], 32'd0);
    repeat (2) tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    idle();
    set_rd(5'd9, 5'd10);
    #1;
    chk("x9_cleared", rd_data[31:0], 32'd0);
    chk("x10_not_busy", {30'd0, rd_busy}, 32'd0);
    set_rd(5'd5, 5'd7);
    #1;
    chk("x5_cleared", rd_data[31:0], 32'd0);
    chk("x7_cleared", rd_data[63:32], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
